mic_fifo_ctrl: RTL and testbench
================================

// Module: mic_fifo_ctrl
// PURPOSE
//  Sequencer for the microphone PCM sample FIFO. Turns mic deserializer sample strobes into
//  one-cycle FIFO write pulses. Holds playback until a prefill level is reached, then drains
//  one sample per play_tick to the audio output. Tracks occupancy and counts overflow/underflow.
//  Sits between mic front end, FIFO instance and PCM playback/bus reader.
// PARAMETERS
//  DAT_WIDTH  18  sample width; equals FIFO data width
//  ADR_WIDTH  4   FIFO address width; depth D = 2**ADR_WIDTH
//  PREFILL    8   level (1..D) at which FILL moves to PLAY
//  CNT_WIDTH  8   width of saturating error counters
// PORTS
//  clk         in   1            system clock, all logic on rising edge
//  reset_n     in   1            asynchronous active-low reset; FIFO instance reset from same source
//  enable      in   1            1 = run capture/playback; 0 = stop capture and drain
//  mic_valid   in   1            one-cycle strobe, new mic sample on mic_data
//  mic_data    in   DAT_WIDTH    mic PCM sample
//  play_tick   in   1            one-cycle sample-rate strobe from playback side
//  play_data   out  DAT_WIDTH    sample delivered to playback
//  play_valid  out  1            one-cycle strobe, play_data valid
//  fifo_wr     out  1            FIFO write pulse
//  fifo_din    out  DAT_WIDTH    FIFO write data
//  fifo_rd     out  1            FIFO read pulse
//  fifo_dout   in   DAT_WIDTH    FIFO head data (combinational from FIFO)
//  fifo_full   in   1            FIFO full flag, cross-check only
//  fifo_empty  in   1            FIFO empty flag, cross-check only
//  level       out  ADR_WIDTH+1  controller occupancy count, 0..D
//  state       out  2            0 IDLE, 1 FILL, 2 PLAY, 3 DRAIN
//  ovf_cnt     out  CNT_WIDTH    dropped mic samples, saturating
//  unf_cnt     out  CNT_WIDTH    play_ticks with no data, saturating
//  clr_err     in   1            synchronous clear of ovf_cnt/unf_cnt; wins over increment
// BEHAVIOUR
//  Reset
//   - All outputs 0; state=IDLE; level=0.
//   - Reset mid-operation aborts any pending pulse. Next pulse is issued no earlier than
//     the 2nd cycle after reset_n rises.
//  Decision timing
//   - Decisions in cycle N use registered state and level.
//   - fifo_wr/fifo_rd are high for exactly cycle N+1. fifo_din is registered with fifo_wr.
//   - level updates at end of N: +1 write only, -1 read only, unchanged for both or neither.
//   - Read data: play_data <= fifo_dout at the end of N+1, so play_valid is high in N+2.
//     Latency play_tick -> play_valid = 2 cycles. play_data holds its value between strobes.
//  Write rule (FILL or PLAY only)
//   - mic_valid && level<D: write.
//   - mic_valid && level==D && a read is issued the same cycle: write.
//   - Otherwise: drop, ovf_cnt+1.
//   - mic_valid in IDLE/DRAIN: ignored, not counted.
//  Read rule
//   - In PLAY, play_tick && level>0: read.
//   - In PLAY, play_tick && level==0: no fifo_rd, no play_valid, unf_cnt+1, state->FILL.
//   - Never assert fifo_rd when level==0, including a same-cycle write into an empty FIFO.
//   - play_tick in IDLE/FILL: ignored, not counted.
//  State machine
//   - IDLE : enable=1 -> FILL.
//   - FILL : enable=0 -> DRAIN; level(next)>=PREFILL -> PLAY. enable=0 has priority.
//   - PLAY : enable=0 -> DRAIN; underflow -> FILL.
//   - DRAIN: issue one read every cycle while level>0, 1 cycle apart, no play_valid.
//            level==0 -> IDLE, even if enable returned to 1. DRAIN always completes.
//  Counters
//   - Saturate at 2**CNT_WIDTH-1.
//   - clr_err sets 0 in the same cycle and discards any increment that cycle.
//  Consistency
//   - level==0 <-> fifo_empty and level==D <-> fifo_full, once pending pulses settle.
//   - Bench asserts this; the RTL does not use the flags.
// TESTING
//  1 Reset mid-PLAY with level=5 -> all outputs 0, state=IDLE, level=0 next cycle;
//    no fifo_wr/rd for 2 cycles after reset_n rises.
//  2 enable=1, 8 mic_valid, no tick (PREFILL=8) -> 8 fifo_wr pulses at N+1, level=8, state=PLAY;
//    tick -> play_valid at +2 with 1st sample.
//  3 Fill to 16 (D=16), 3 more mic_valid, no tick -> no fifo_wr, ovf_cnt=3, level=16;
//    mic_valid+play_tick same cycle -> wr and rd, level=16.
//  4 PLAY with level=1: tick, then tick -> 1 play_valid; 2nd tick gives unf_cnt=1, no fifo_rd,
//    state=FILL; with CNT_WIDTH=8, 300 underflows -> unf_cnt=255.
//  5 level=0 in PLAY, mic_valid+play_tick same cycle -> write only, level=1, unf_cnt+1, state=FILL.
//  6 level=6, enable=0 -> DRAIN, 6 consecutive fifo_rd, level=0, state=IDLE,
//    fifo_empty=1, play_valid never high; clr_err with an ovf event -> ovf_cnt=0.

Source files
------------

// File: rtl/mic_fifo_ctrl.sv
// Mic PCM FIFO sequencer: turns mic strobes into FIFO writes, prefills, then
// paces reads from play_tick, with occupancy tracking and saturating error counters.
module mic_fifo_ctrl #(
  parameter int DAT_WIDTH = 18,
  parameter int ADR_WIDTH = 4,
  parameter int PREFILL   = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 mic_valid,
  input  logic [DAT_WIDTH-1:0] mic_data,
  input  logic                 play_tick,
  output logic [DAT_WIDTH-1:0] play_data,
  output logic                 play_valid,
  output logic                 fifo_wr,
  output logic [DAT_WIDTH-1:0] fifo_din,
  output logic                 fifo_rd,
  input  logic [DAT_WIDTH-1:0] fifo_dout,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  output logic [ADR_WIDTH:0]   level,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [CNT_WIDTH-1:0] unf_cnt,
  input  logic                 clr_err
);

  localparam int LVL_W = ADR_WIDTH + 1;
  localparam logic [LVL_W-1:0] DEPTH       = LVL_W'(2**ADR_WIDTH);
  localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [LVL_W-1:0]     level_reg, level_next;
  logic                 fifo_wr_reg, fifo_rd_reg;
  logic                 play_pend_reg, play_valid_reg;
  logic [DAT_WIDTH-1:0] fifo_din_reg, play_data_reg;

  logic capture, lvl_empty, lvl_full;
  logic wr_dec, rd_dec, play_dec, ovf_inc, unf_inc;

  assign capture   = (state_reg == ST_FILL) || (state_reg == ST_PLAY);
  assign lvl_empty = (level_reg == '0);
  assign lvl_full  = (level_reg == DEPTH);

  // Reads never issue at level 0; a same-cycle write into an empty FIFO is write-only.
  assign play_dec = (state_reg == ST_PLAY) && play_tick && !lvl_empty;
  assign unf_inc  = (state_reg == ST_PLAY) && play_tick && lvl_empty;
  assign rd_dec   = play_dec || ((state_reg == ST_DRAIN) && !lvl_empty);
  assign wr_dec   = capture && mic_valid && (!lvl_full || rd_dec);
  assign ovf_inc  = capture && mic_valid && !wr_dec;

  always_comb begin
    level_next = level_reg;
    if (wr_dec && !rd_dec)
      level_next = level_reg + 1'b1;
    else if (rd_dec && !wr_dec)
      level_next = level_reg - 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_FILL;
      ST_FILL: begin
        if (!enable)                         state_next = ST_DRAIN;
        else if (level_next >= PREFILL_LVL)  state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (!enable)      state_next = ST_DRAIN;
        else if (unf_inc) state_next = ST_FILL;
      end
      ST_DRAIN: if (lvl_empty) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      level_reg      <= '0;
      fifo_wr_reg    <= 1'b0;
      fifo_rd_reg    <= 1'b0;
      play_pend_reg  <= 1'b0;
      play_valid_reg <= 1'b0;
      fifo_din_reg   <= '0;
      play_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      fifo_wr_reg    <= wr_dec;
      fifo_rd_reg    <= rd_dec;
      play_pend_reg  <= play_dec;
      play_valid_reg <= play_pend_reg;
      if (wr_dec)
        fifo_din_reg <= mic_data;
      // Head data is captured in the cycle the read pulse is on the FIFO.
      if (play_pend_reg)
        play_data_reg <= fifo_dout;
    end
  end

  logic [1:0]                err_inc;
  logic [1:0][CNT_WIDTH-1:0] err_cnt;
  assign err_inc = {unf_inc, ovf_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          cnt_reg <= '0;
        else if (clr_err)
          cnt_reg <= '0;
        else if (err_inc[gi] && (cnt_reg != {CNT_WIDTH{1'b1}}))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign err_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign ovf_cnt    = err_cnt[0];
  assign unf_cnt    = err_cnt[1];
  assign state      = state_reg;
  assign level      = level_reg;
  assign fifo_wr    = fifo_wr_reg;
  assign fifo_rd    = fifo_rd_reg;
  assign fifo_din   = fifo_din_reg;
  assign play_valid = play_valid_reg;
  assign play_data  = play_data_reg;

endmodule

// File: tb/tb_mic_fifo_ctrl.sv
// Self-checking bench for mic_fifo_ctrl: behavioural FIFO plus a queue-based
// reference model, directed scenarios followed by randomized traffic.
module tb_mic_fifo_ctrl;
  localparam int DW = 18;
  localparam int D  = 16;
  localparam int PF = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0, mic_valid = 1'b0, play_tick = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] mic_data = '0;
  logic [DW-1:0] play_data, fifo_din;
  logic          play_valid, fifo_wr, fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [4:0]    level;
  logic [1:0]    state;
  logic [7:0]    ovf_cnt, unf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mic_fifo_ctrl #(.DAT_WIDTH(DW), .ADR_WIDTH(4), .PREFILL(PF), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mic_valid(mic_valid),
    .mic_data(mic_data), .play_tick(play_tick), .play_data(play_data),
    .play_valid(play_valid), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .level(level), .state(state),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .clr_err(clr_err)
  );

  // Behavioural FIFO driven by the DUT pulses, reset from the same source.
  logic [DW-1:0] fq[$];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr && fq.size() < D) fq.push_back(fifo_din);
      fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
      fifo_empty <= (fq.size() == 0);
      fifo_full  <= (fq.size() == D);
    end
  end

  // Reference model: content queue, mode (0 idle,1 fill,2 play,3 drain), counters.
  logic [DW-1:0] mq[$];
  int            m_state = 0, m_ovf = 0, m_unf = 0;
  bit            e_wr = 0, e_rd = 0, e_pv = 0, pend_pv = 0;
  logic [DW-1:0] e_din = '0, e_pd = '0, pend_pd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("level", 32'(level), 32'(mq.size()));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("unf_cnt", 32'(unf_cnt), 32'(m_unf));
    chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
    chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
    if (e_wr) chk("fifo_din", 32'(fifo_din), 32'(e_din));
    chk("play_valid", 32'(play_valid), 32'(e_pv));
    chk("play_data", 32'(play_data), 32'(e_pd));
    if (!e_wr && !e_rd) begin
      chk("empty_flag", 32'(fifo_empty), 32'(mq.size() == 0));
      chk("full_flag", 32'(fifo_full), 32'(mq.size() == D));
    end
  endtask

  task automatic step(input bit mv, input bit pt, input bit en, input bit clr);
    logic [DW-1:0] md;
    int  lvl;
    bit  cap, play, rd, wr, unf;
    md = DW'($urandom);
    mic_valid = mv; mic_data = md; play_tick = pt; enable = en; clr_err = clr;
    lvl  = mq.size();
    cap  = (m_state == 1) || (m_state == 2);
    play = (m_state == 2) && pt && (lvl > 0);
    rd   = play || ((m_state == 3) && (lvl > 0));
    unf  = (m_state == 2) && pt && (lvl == 0);
    wr   = cap && mv && ((lvl < D) || rd);
    e_pv = pend_pv;
    if (pend_pv) e_pd = pend_pd;
    pend_pv = play;
    if (rd) pend_pd = mq.pop_front();
    if (wr) begin
      mq.push_back(md);
      e_din = md;
    end
    e_wr = wr;
    e_rd = rd;
    if (clr) m_ovf = 0;
    else if (cap && mv && !wr && m_ovf < CMAX) m_ovf++;
    if (clr) m_unf = 0;
    else if (unf && m_unf < CMAX) m_unf++;
    case (m_state)
      0: if (en) m_state = 1;
      1: if (!en) m_state = 3; else if (mq.size() >= PF) m_state = 2;
      2: if (!en) m_state = 3; else if (unf) m_state = 1;
      default: if (lvl == 0) m_state = 0;
    endcase
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    mq.delete();
    m_state = 0; m_ovf = 0; m_unf = 0;
    e_wr = 0; e_rd = 0; e_pv = 0; pend_pv = 0;
    e_din = '0; e_pd = '0; pend_pd = '0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wr", 32'(fifo_wr), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_pv", 32'(play_valid), 32'd0);
    chk("rst_pd", 32'(play_data), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_unf", 32'(unf_cnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // Bring up to PLAY, read down to 5, then reset mid-operation.
    step(1, 0, 1, 0);
    repeat (PF) step(1, 0, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    chk("pre_rst_level", 32'(level), 32'd5);
    do_reset();
    // Mic strobes held during the first cycles after release: no pulse yet.
    step(1, 0, 1, 0);
    // Prefill then one tick with 2-cycle play_valid latency.
    repeat (PF) step(1, 0, 1, 0);
    chk("prefill_state", 32'(state), 32'd2);
    step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    // Fill to full, overflow three times, then simultaneous write and read at full.
    repeat (D - PF + 1) step(1, 0, 1, 0);
    repeat (3) step(1, 0, 1, 0);
    chk("ovf_three", 32'(ovf_cnt), 32'd3);
    step(1, 1, 1, 0);
    chk("full_wr_rd_level", 32'(level), 32'(D));
    // Read down to 1, last sample, then underflow.
    repeat (D - 1) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("unf_state_fill", 32'(state), 32'd1);
    // Repeated underflows to reach saturation.
    for (int i = 0; i < 300; i++) begin
      repeat (PF) step(1, 0, 1, 0);
      repeat (PF + 1) step(0, 1, 1, 0);
    end
    chk("unf_saturated", 32'(unf_cnt), 32'd255);
    // Empty in PLAY with same-cycle write and tick: write only.
    repeat (PF) step(1, 0, 1, 0);
    repeat (PF) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("wr_only_level", 32'(level), 32'd1);
    // Drain from level 6.
    repeat (PF - 1) step(1, 0, 1, 0);
    repeat (2) step(0, 1, 1, 0);
    repeat (9) step(0, 0, 0, 0);
    chk("drain_idle", 32'(state), 32'd0);
    // Clear wins over a same-cycle overflow increment.
    step(0, 0, 1, 0);
    repeat (D + 2) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    chk("clr_ovf", 32'(ovf_cnt), 32'd0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 60) != 0, ($urandom % 100) == 0);
    step(0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
